// File: rtl/stream_arbiter_rr_if.sv
// Bundled upstream/downstream stream signals of the round-robin arbiter.
// The master modport is the arbiter's view; slave is the producers'/consumer's view.
interface stream_arbiter_rr_if #(
  parameter int WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  localparam int SRC_W = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS*WIDTH-1:0] i_in_data;
  logic [NUM_INPUTS-1:0]       i_in_valid;
  logic [NUM_INPUTS-1:0]       i_in_last;
  logic [NUM_INPUTS-1:0]       o_in_ready;
  logic [WIDTH-1:0]            o_out_data;
  logic                        o_out_last;
  logic [SRC_W-1:0]            o_out_source;
  logic                        o_out_valid;
  logic                        i_out_ready;

  modport master (
    input  i_in_data, i_in_valid, i_in_last, i_out_ready,
    output o_in_ready, o_out_data, o_out_last, o_out_source, o_out_valid
  );

  modport slave (
    output i_in_data, i_in_valid, i_in_last, i_out_ready,
    input  o_in_ready, o_out_data, o_out_last, o_out_source, o_out_valid
  );
endinterface

// File: rtl/stream_arbiter_rr.sv
// Packet-atomic round-robin arbiter with a two-entry skid output stage;
// every output and every per-input ready is driven straight from a flop.
module stream_arbiter_rr #(
  parameter int WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  localparam int SRC_W = $clog2(NUM_INPUTS)
) (
  input logic i_clock,
  input logic i_reset,
  stream_arbiter_rr_if.master bus
);
  localparam int BEAT_W = WIDTH + 1 + SRC_W;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                r_state, w_state_next;
  logic [SRC_W-1:0]      r_grant, w_grant_next;
  logic [SRC_W-1:0]      r_ptr, w_ptr_next;
  logic [SRC_W-1:0]      w_pick;
  logic                  w_any_valid;
  logic [NUM_INPUTS-1:0] r_in_ready, w_in_ready_next;
  logic [BEAT_W-1:0]     r_main, w_main_next, r_skid, w_skid_next, w_in_beat;
  logic                  r_main_valid, w_main_valid_next;
  logic                  r_skid_valid, w_skid_valid_next;
  logic                  w_in_fire, w_out_fire;
  logic [WIDTH-1:0]      w_in_data [NUM_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_split
      assign w_in_data[gi] = bus.i_in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Beat layout: {data, last, source}
  assign w_in_beat  = {w_in_data[r_grant], bus.i_in_last[r_grant], r_grant};
  assign w_in_fire  = r_in_ready[r_grant] & bus.i_in_valid[r_grant];
  assign w_out_fire = r_main_valid & bus.i_out_ready;

  // Scan downward so the lowest offset from ptr is the one left standing.
  always_comb begin
    logic [SRC_W-1:0] v_idx;
    v_idx       = '0;
    w_pick      = r_ptr;
    w_any_valid = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      v_idx = SRC_W'((int'(r_ptr) + k) % NUM_INPUTS);
      if (bus.i_in_valid[v_idx]) begin
        w_pick      = v_idx;
        w_any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_next = S_LOCKED;
          w_grant_next = w_pick;
        end
      end
      S_LOCKED: begin
        if (w_in_fire && bus.i_in_last[r_grant]) begin
          w_state_next = S_IDLE;
          w_ptr_next   = (r_grant == SRC_W'(NUM_INPUTS - 1)) ? '0 : r_grant + SRC_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Skid fills only when main is held; an output transfer drains skid first.
  always_comb begin
    w_main_next       = r_main;
    w_main_valid_next = r_main_valid;
    w_skid_next       = r_skid;
    w_skid_valid_next = r_skid_valid;
    if (w_out_fire) begin
      if (r_skid_valid) begin
        w_main_next       = r_skid;
        w_skid_valid_next = 1'b0;
      end else if (w_in_fire) begin
        w_main_next = w_in_beat;
      end else begin
        w_main_valid_next = 1'b0;
      end
    end else if (w_in_fire) begin
      if (r_main_valid) begin
        w_skid_next       = w_in_beat;
        w_skid_valid_next = 1'b1;
      end else begin
        w_main_next       = w_in_beat;
        w_main_valid_next = 1'b1;
      end
    end
  end

  // Ready is computed from next state so it can be registered.
  always_comb begin
    w_in_ready_next = '0;
    if (w_state_next == S_LOCKED && !w_skid_valid_next) begin
      w_in_ready_next[w_grant_next] = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_in_ready   <= '0;
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_ptr        <= w_ptr_next;
      r_in_ready   <= w_in_ready_next;
      r_main       <= w_main_next;
      r_main_valid <= w_main_valid_next;
      r_skid       <= w_skid_next;
      r_skid_valid <= w_skid_valid_next;
    end
  end

  assign bus.o_in_ready   = r_in_ready;
  assign bus.o_out_valid  = r_main_valid;
  assign bus.o_out_data   = r_main[SRC_W+1 +: WIDTH];
  assign bus.o_out_last   = r_main[SRC_W];
  assign bus.o_out_source = r_main[SRC_W-1:0];
endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Randomized scoreboard bench: a packet-level model predicts grants, ready and
// the output beat stream; a separate monitor compares every output cycle.
module tb_stream_arbiter_rr;
  localparam int WIDTH = 16;
  localparam int NI    = 4;
  localparam int SRC_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [SRC_W-1:0] src;
  } beat_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  stream_arbiter_rr_if #(.WIDTH(WIDTH), .NUM_INPUTS(NI)) bus();
  stream_arbiter_rr #(.WIDTH(WIDTH), .NUM_INPUTS(NI)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WIDTH:0] src_q [NI][$];   // per-input pending beats {last, data}
  beat_t          sb_q [$];        // beats accepted but not yet delivered
  int             gap_pct [NI];
  int             out_mode   = 0;
  int             rst_cycles = 3;
  bit             m_locked   = 1'b0;
  int             m_grant    = 0;
  int             m_ptr      = 0;
  bit             pend_pop   = 1'b0;
  bit             first_beat = 1'b1;
  int             out_cyc [$];
  int             pkt_src [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clock) cyc <= cyc + 1;

  // Drivers and reference model: inputs change mid-cycle, and the transfer
  // that will happen on the next rising edge is predicted here.
  always @(negedge i_clock) begin
    logic [NI-1:0]  exp_rdy, vld, lst;
    logic [WIDTH:0] b;
    beat_t          e;
    exp_rdy = '0;
    if (m_locked && sb_q.size() < 2) exp_rdy[m_grant] = 1'b1;
    chk("in_ready", 64'(bus.o_in_ready), 64'(exp_rdy));
    if (rst_cycles > 0) begin
      rst_cycles--;
      i_reset = 1'b1;
      for (int n = 0; n < NI; n++) src_q[n].delete();
      bus.i_in_valid = '0;
      bus.i_in_last  = '0;
      sb_q.delete();
      m_locked = 1'b0;
      m_grant  = 0;
      m_ptr    = 0;
    end else begin
      i_reset = 1'b0;
      for (int n = 0; n < NI; n++) begin
        vld[n] = (src_q[n].size() > 0) && ($urandom_range(99) >= 32'(gap_pct[n]));
        if (vld[n]) begin
          b = src_q[n][0];
          bus.i_in_data[n*WIDTH +: WIDTH] = b[WIDTH-1:0];
          lst[n] = b[WIDTH];
        end else begin
          bus.i_in_data[n*WIDTH +: WIDTH] = WIDTH'($urandom);
          lst[n] = 1'($urandom);
        end
      end
      bus.i_in_valid = vld;
      bus.i_in_last  = lst;
      if (m_locked) begin
        if (vld[m_grant] && bus.o_in_ready[m_grant]) begin
          b = src_q[m_grant].pop_front();
          e.data = b[WIDTH-1:0];
          e.last = b[WIDTH];
          e.src  = SRC_W'(m_grant);
          sb_q.push_back(e);
          if (b[WIDTH]) begin
            m_locked = 1'b0;
            m_ptr    = (m_grant + 1) % NI;
          end
        end
      end else if (vld != '0) begin
        for (int k = 0; k < NI; k++) begin
          if (vld[(m_ptr + k) % NI]) begin
            m_grant = (m_ptr + k) % NI;
            break;
          end
        end
        m_locked = 1'b1;
      end
    end
  end

  // Monitor: compares the presented beat with the scoreboard head every cycle.
  always @(posedge i_clock) begin
    beat_t e;
    #1;
    if (i_reset) begin
      pend_pop   = 1'b0;
      first_beat = 1'b1;
      chk("reset_outs", 64'({bus.o_out_valid, bus.o_in_ready, bus.o_out_data,
                             bus.o_out_last, bus.o_out_source}), 64'(0));
    end else begin
      if (pend_pop && sb_q.size() > 0) void'(sb_q.pop_front());
      if (sb_q.size() == 0) begin
        chk("out_valid", 64'(bus.o_out_valid), 64'(0));
      end else begin
        e = sb_q[0];
        chk("out_beat", 64'({bus.o_out_valid, bus.o_out_data, bus.o_out_last, bus.o_out_source}),
            64'({1'b1, e}));
      end
      case (out_mode)
        0:       bus.i_out_ready = 1'b1;
        1:       bus.i_out_ready = 1'($urandom);
        2:       bus.i_out_ready = (cyc % 5) < 2;
        default: bus.i_out_ready = 1'b0;
      endcase
      pend_pop = bus.o_out_valid && bus.i_out_ready;
      if (pend_pop) begin
        out_cyc.push_back(cyc);
        if (first_beat) pkt_src.push_back(int'(bus.o_out_source));
        first_beat = bus.o_out_last;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge i_clock);
    #2;
  endtask

  task automatic add_pkt(input int n, input int len, input int base);
    for (int i = 0; i < len; i++) src_q[n].push_back({(i == len - 1), WIDTH'(base + i)});
  endtask

  function automatic bit busy();
    busy = (sb_q.size() != 0);
    for (int n = 0; n < NI; n++) if (src_q[n].size() != 0) busy = 1'b1;
  endfunction

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      wait_cycles(1);
      k++;
    end
    chk(name, 64'(busy()), 64'(0));
  endtask

  task automatic clear_logs();
    out_cyc.delete();
    pkt_src.delete();
  endtask

  initial begin
    int t0, nbeats, len;
    bus.i_in_valid  = '0;
    bus.i_in_last   = '0;
    bus.i_in_data   = '0;
    bus.i_out_ready = 1'b1;
    for (int n = 0; n < NI; n++) gap_pct[n] = 0;
    wait_cycles(6);

    // Idle: nothing may appear
    clear_logs();
    wait_cycles(100);
    chk("idle_beats", 64'(out_cyc.size()), 64'(0));

    // Latency: input 2, 4 beats
    clear_logs();
    t0 = cyc;
    add_pkt(2, 4, 'h10);
    drain(200, "lat_drain");
    chk("lat_count", 64'(out_cyc.size()), 64'(4));
    if (out_cyc.size() == 4) begin
      chk("lat_first", 64'(out_cyc[0] - t0), 64'(2));
      chk("lat_span", 64'(out_cyc[3] - out_cyc[0]), 64'(3));
      chk("lat_src", 64'(pkt_src[0]), 64'(2));
    end

    // Fairness: all inputs continuously offer 2-beat packets
    clear_logs();
    for (int p = 0; p < 4; p++)
      for (int n = 0; n < NI; n++) add_pkt(n, 2, (n << 8) | (p << 4));
    drain(500, "rr_drain");
    chk("rr_pkts", 64'(pkt_src.size()), 64'(16));
    if (pkt_src.size() == 16) begin
      chk("rr_start", 64'(pkt_src[0]), 64'(3));
      for (int i = 1; i < 16; i++) chk("rr_order", 64'(pkt_src[i]), 64'((pkt_src[i-1] + 1) % NI));
    end
    if (out_cyc.size() == 32)
      for (int i = 1; i < 32; i++) chk("rr_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'((i % 2) ? 1 : 2));

    // Bursty downstream: 2 high / 3 low
    clear_logs();
    out_mode = 2;
    add_pkt(1, 16, 'h100);
    drain(1000, "bd_drain");
    chk("bd_count", 64'(out_cyc.size()), 64'(16));
    out_mode = 0;

    // Bursty requester: input 0 with gaps, input 3 waiting
    clear_logs();
    gap_pct[0] = 50;
    add_pkt(0, 6, 'h200);
    t0 = 0;
    while (!(m_locked && m_grant == 0) && t0 < 100) begin
      wait_cycles(1);
      t0++;
    end
    chk("br_grant0", 64'(m_locked && m_grant == 0), 64'(1));
    add_pkt(3, 3, 'h300);
    drain(500, "br_drain");
    gap_pct[0] = 0;
    chk("br_pkts", 64'(pkt_src.size()), 64'(2));
    if (pkt_src.size() == 2) begin
      chk("br_first", 64'(pkt_src[0]), 64'(0));
      chk("br_second", 64'(pkt_src[1]), 64'(3));
    end

    // Reset mid-packet with skid full; ptr left at 2 beforehand
    add_pkt(1, 1, 'h400);
    drain(100, "rs_pre");
    out_mode = 3;
    add_pkt(2, 5, 'h500);
    t0 = 0;
    while (sb_q.size() < 2 && t0 < 50) begin
      wait_cycles(1);
      t0++;
    end
    chk("rs_skid_full", 64'(sb_q.size()), 64'(2));
    wait_cycles(2);
    rst_cycles = 1;
    wait_cycles(3);
    out_mode = 0;
    clear_logs();
    add_pkt(1, 2, 'h600);
    add_pkt(3, 2, 'h700);
    drain(200, "rs_drain");
    chk("rs_pkts", 64'(pkt_src.size()), 64'(2));
    if (pkt_src.size() == 2) begin
      chk("rs_first", 64'(pkt_src[0]), 64'(1));
      chk("rs_second", 64'(pkt_src[1]), 64'(3));
    end

    // Random traffic with random gaps and random downstream stalls
    clear_logs();
    out_mode = 1;
    nbeats = 0;
    for (int n = 0; n < NI; n++) gap_pct[n] = $urandom_range(40);
    for (int i = 0; i < 60; i++) begin
      len = $urandom_range(5, 1);
      add_pkt($urandom_range(NI - 1), len, $urandom_range(16'hffff));
      nbeats += len;
    end
    drain(8000, "rnd_drain");
    chk("rnd_count", 64'(out_cyc.size()), 64'(nbeats));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_arbiter_rr.md
# stream_arbiter_rr

Round-robin arbiter that shares one downstream valid/ready stream channel among NUM_INPUTS upstream requesters. Grants are packet-atomic: once an input wins, it keeps the channel until its beat flagged last is accepted. The output stage is a two-entry skid register, so every output and every o_in_ready bit is driven from flops. The block sits between the per-source producers and the shared datapath consumer.

## Interface
- WIDTH, 16, data bits per beat
- NUM_INPUTS, 4, number of requesters (≥2, need not be a power of two)
- SRC_W, $clog2(NUM_INPUTS), source index width (derived, not overridden)

- i_clock  in  1  clock; all logic on the rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_in_data  in  NUM_INPUTS*WIDTH  input n occupies bits [n*WIDTH +: WIDTH]
- i_in_valid  in  NUM_INPUTS  per-input valid
- i_in_last  in  NUM_INPUTS  per-input end-of-packet flag, qualified by valid
- o_in_ready  out  NUM_INPUTS  per-input ready, at most one bit high (registered)
- o_out_data  out  WIDTH  granted beat data
- o_out_last  out  1  end-of-packet flag of the output beat
- o_out_source  out  SRC_W  input index the output beat came from
- o_out_valid  out  1  output beat present
- i_out_ready  in  1  downstream accept

## Operation
- Transfer rule: a beat moves on a rising edge when valid and ready are both high on that port, on either side.
- The FSM has two states.
  - IDLE: no grant. If any i_in_valid is high, select the first valid index at or after ptr, searching upward and wrapping modulo NUM_INPUTS. Register it as grant and go to LOCKED.
  - LOCKED: o_in_ready[grant] = ~skid_full. All other ready bits are 0.
  - LOCKED → IDLE on the edge that accepts a beat from input grant with i_in_last=1. On that edge ptr ← (grant+1) mod NUM_INPUTS.
- Non-granted valid inputs are ignored while LOCKED. Their data is never sampled.
- Valid dropping on the granted input mid-packet is legal. The grant is held, no beat transfers, and no timeout applies.
- Output stage has two entries.
  - main: drives o_out_*.
  - skid: a spill entry filled only when main is held (o_out_valid & ~i_out_ready) and an input beat is accepted.
  - On an output transfer, skid (if full) moves to main. Otherwise the accepted input beat (if any) moves to main. Otherwise main empties.
  - Order is preserved. No beat is dropped or duplicated.
- Each beat stores {data, last, source}. Source is the grant index at acceptance.
- Reset: state=IDLE, ptr=0, both entries empty.

## Timing
- Reset values: o_out_valid=0, o_in_ready=0, o_out_data=0, o_out_last=0, o_out_source=0.
- A reset asserted mid-packet discards buffered beats and the in-progress grant. No partial flush is performed.
- Arbitration latency:
  - Valid rises in cycle 0 (in IDLE), grant registers at edge 1, and o_in_ready is high in cycle 1.
  - The first beat is accepted at edge 2 and o_out_valid is high in cycle 2.
- Throughput: one beat per cycle within a packet when i_out_ready is held high. Exactly one bubble cycle of o_in_ready=0 follows each packet's last beat, for re-arbitration.
- Backpressure: o_in_ready drops the cycle after skid fills. One accepted beat always fits, so registered ready is safe.
- i_out_ready may toggle every cycle. o_out_* hold stable while o_out_valid & ~i_out_ready.
- Simultaneous output accept and input accept with skid full is impossible, because ready is 0 in that case.
- ptr wraps from NUM_INPUTS-1 to 0. With NUM_INPUTS=3, the order after winning index 2 is 0,1,2.

## Test plan
- **Idle.** After reset, hold all valid=0 for 100 cycles → o_out_valid and o_in_ready stay 0 and no beats appear.
- **Latency.** Input 2 sends a 4-beat packet 0x10..0x13 with i_out_ready=1 → first beat appears 2 cycles after valid. o_out_source=2, data 0x10..0x13 arrive on consecutive cycles, and last=1 only on 0x13.
- **Round-robin fairness.** All 4 inputs continuously present 2-beat packets tagged with their index → grant order is 0,1,2,3,0,… with one bubble between packets and no interleaving within a packet.
- **Bursty downstream.** Input 1 sends 16 incrementing beats while i_out_ready toggles 2 cycles high and 3 cycles low → all 16 are received in order with no loss or duplication, and o_out_* stay stable while stalled.
- **Bursty requester.** Input 0 sends a packet with valid gaps while input 3 is continuously valid → input 3 gets no ready until input 0's last beat, then wins next.
- **Reset mid-packet.** Assert reset after beat 2 of 5 with skid full → the next cycle has all outputs 0. Afterwards, a new request from input 1 is granted normally and arbitration starts from ptr=0.
